inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction-fetch stage of the MIPS R/I/J datapath. It holds the program counter and fetches one 32-bit word per instruction over a req/ack instruction-memory port. It presents the word to the decode stage (R/I/J analysis blocks) with a valid/ready handshake. When decode accepts an instruction, the unit samples the decoder's `PC_s` selection and branch/jump operands to form the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; always equals `PC`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `Inst_code`  out  32  latched instruction to decode.
- `PC`  out  32  address of `Inst_code`.
- `PC_plus4`  out  32  `PC + 4`, combinational from `PC`.
- `inst_valid`  out  1  `Inst_code` is valid and held.
- `inst_ready`  in  1  decode/execute accepts the instruction; next-PC inputs are valid in this cycle.
- `PC_s`  in  2  next-PC select: 00 `PC+4`, 01 register (jr), 10 branch, 11 jump.
- `imm_offset`  in  16  branch offset (word count, signed).
- `jr_addr`  in  32  rs register value for jr.
- `j_target`  in  26  J-type instr_index.
- `misalign_err`  out  1  sticky flag: a jr target had nonzero `[1:0]`.

## Operation
- Three-state FSM:
  - `S_IDLE`: the reset state.
  - `S_FETCH`: `imem_req` = 1.
  - `S_HOLD`: `inst_valid` = 1.
- `imem_req` and `inst_valid` are Moore outputs, decoded from the state register only.
- Transitions:
  - `S_IDLE` -> `S_FETCH` unconditionally, on the first edge after reset release.
  - `S_FETCH` -> `S_HOLD` when `imem_ack` = 1; `Inst_code` <= `imem_rdata` on the same edge.
  - `S_FETCH` holds while `imem_ack` = 0.
  - `S_HOLD` -> `S_FETCH` when `inst_ready` = 1; `PC` <= next PC on the same edge.
  - `S_HOLD` holds while `inst_ready` = 0; `Inst_code` and `PC` are frozen.
- Next-PC arithmetic, all modulo 2^32 (wrap silently, no error):
  - 00: `PC + 4`.
  - 01: `{jr_addr[31:2], 2'b00}`. If `jr_addr[1:0]` != 0, `misalign_err` <= 1.
  - 10: `PC + 4 + (sign_extend(imm_offset) << 2)`.
  - 11: `{PC_plus4[31:28], j_target, 2'b00}`.
- `imem_ack` is ignored outside `S_FETCH`. `inst_ready` is ignored outside `S_HOLD`.
- `PC_s`, `imm_offset`, `jr_addr` and `j_target` are don't-care except in an `S_HOLD` cycle with `inst_ready` = 1.
- `misalign_err` clears only on reset.
- Reset values:
  - state = `S_IDLE`; `PC` = `RESET_PC`; `Inst_code` = 32'h0000_0000.
  - `imem_req` = 0, `inst_valid` = 0, `misalign_err` = 0.
  - `imem_addr` = `RESET_PC`.
- Reset asserted mid-fetch or mid-hold: all state returns to reset values immediately (asynchronous). A pending memory ack is discarded, and the fetch restarts at `RESET_PC`.

## Timing
- Zero-wait memory (`imem_ack` in the first `S_FETCH` cycle) with `inst_ready` held high: 2 cycles per instruction, `S_FETCH` then `S_HOLD`.
- Each memory wait cycle adds 1 cycle. Each `inst_ready` = 0 cycle in `S_HOLD` adds 1 cycle.
- The new `PC`/`imem_addr` is visible the cycle after the accepting edge, together with `imem_req` = 1.
- `imem_addr` is stable for the whole `S_FETCH` residency.
- `Inst_code` changes only on the `S_FETCH` -> `S_HOLD` edge.
- No combinational path from any input to `imem_req`, `inst_valid` or `imem_addr`.

## Test plan
- Reset/first fetch:
  - Stimulus: hold `rst_n` = 0, then release.
  - Required: all outputs at reset values; one cycle later `imem_req` = 1, `imem_addr` = `RESET_PC`.
  - Stimulus: ack with 32'h2008_0005.
  - Required: `inst_valid` = 1, `Inst_code` = 32'h2008_0005 next cycle.
- Sequential + wrap:
  - Stimulus: `PC` = 32'hFFFF_FFFC, `PC_s` = 00, `inst_ready` = 1.
  - Required: next `imem_addr` = 32'h0000_0000, no error flag.
- Branch backward:
  - Stimulus: `PC` = 32'h0000_0010, `PC_s` = 10, `imm_offset` = 16'hFFFC.
  - Required: next `PC` = 32'h0000_0004.
- Jump and jr:
  - `PC` = 32'h3000_0008, `PC_s` = 11, `j_target` = 26'h000_0040 -> next `PC` = 32'h3000_0100.
  - `PC_s` = 01, `jr_addr` = 32'h0000_1236 -> next `PC` = 32'h0000_1234, `misalign_err` = 1 and stays 1.
- Handshake stalls:
  - Stimulus: `imem_ack` delayed 3 cycles; `inst_ready` = 0 for 2 cycles.
  - Required: `imem_addr` stable for 4 `S_FETCH` cycles; `Inst_code`/`PC` frozen in `S_HOLD`.
  - Stimulus: `imem_ack` pulse during `S_HOLD`.
  - Required: ignored, `Inst_code` unchanged.
- Reset mid-fetch:
  - Stimulus: drop `rst_n` during a wait-state fetch at `PC` = 32'h0000_0040, with `imem_ack` = 1 during reset.
  - Required: immediate return to reset values; refetch starts at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: MIPS instruction-fetch stage.
// Holds the PC, fetches one word per instruction over a req/ack memory port,
// presents it to decode with valid/ready, and forms the next PC from the
// decoder's PC_s select when decode accepts.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/ack/rdata    instruction memory port
//   Inst_code, PC, PC_plus4    instruction to decode and its address
//   inst_valid, inst_ready     decode handshake
//   PC_s, imm_offset, jr_addr, j_target  next-PC controls (sampled on accept)
//   misalign_err               sticky: jr target with nonzero [1:0]
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst_code,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [1:0]  PC_s,
  input  logic [15:0] imm_offset,
  input  logic [31:0] jr_addr,
  input  logic [25:0] j_target,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign PC_plus4 = pc_q + 32'd4;

  // Next-PC mux; all adds wrap modulo 2^32.
  always_comb begin
    next_pc = PC_plus4;
    case (PC_s)
      2'b00: next_pc = PC_plus4;
      2'b01: next_pc = {jr_addr[31:2], 2'b00};
      2'b10: next_pc = PC_plus4 + {{14{imm_offset[15]}}, imm_offset, 2'b00};
      2'b11: next_pc = {PC_plus4[31:28], j_target, 2'b00};
      default: next_pc = PC_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_ack) begin
        state_d = S_HOLD;
        inst_d  = imem_rdata;
      end
      S_HOLD:  if (inst_ready) begin
        state_d = S_FETCH;
        pc_d    = next_pc;
        if (PC_s == 2'b01 && jr_addr[1:0] != 2'b00) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  assign imem_req     = (state_q == S_FETCH);
  assign inst_valid   = (state_q == S_HOLD);
  assign imem_addr    = pc_q;
  assign PC           = pc_q;
  assign Inst_code    = inst_q;
  assign misalign_err = err_q;

endmodule
